// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared definitions for the load/store unit.
//   - access size encodings
//   - controller state enum
//   - default data memory depth
//   - alignment/size legality helper
package mem_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DEPTH_WORDS_DEF = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } lsu_state_e;

  // Returns 1 for an illegal size, or for an address misaligned for its size.
  function automatic logic align_err(input logic [1:0] size, input logic [1:0] lo);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = lo[0];
      SZ_WORD: err = (lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/mem_lsu_lane_align.sv
// mem_lane_align: combinational lane handling between a memory word and the
// right-aligned request data (little-endian).
// Ports:
//   word      in  32  word read from memory
//   addr_lo   in  2   byte offset within the word
//   size      in  2   access size (SZ_BYTE/SZ_HALF/SZ_WORD)
//   is_signed in  1   sign-extend sub-word loads
//   wdata     in  32  store data, right-aligned
//   load_val  out 32  extracted and extended load value
//   merged    out 32  word with the store lane replaced by wdata
module mem_lane_align
  import mem_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [4:0]  bit_off_s;

  assign bit_off_s = {addr_lo, 3'b000};

  // Select the addressed byte/half lane and extend it to 32 bits.
  always_comb begin
    byte_s   = word[bit_off_s +: 8];
    half_s   = addr_lo[1] ? word[31:16] : word[15:0];
    load_val = 32'h0000_0000;
    case (size)
      SZ_BYTE: load_val = is_signed ? {{24{byte_s[7]}}, byte_s} : {24'h00_0000, byte_s};
      SZ_HALF: load_val = is_signed ? {{16{half_s[15]}}, half_s} : {16'h0000, half_s};
      SZ_WORD: load_val = word;
      default: load_val = 32'h0000_0000;
    endcase
  end

  // Replace the addressed lane of the read word with the store data.
  always_comb begin
    merged = word;
    case (size)
      SZ_BYTE: merged[bit_off_s +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (addr_lo[1]) begin
          merged[31:16] = wdata[15:0];
        end else begin
          merged[15:0] = wdata[15:0];
        end
      end
      SZ_WORD: merged = wdata;
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit driving a word-addressed data memory.
// Byte-addressed byte/half/word requests arrive over a valid/ready handshake,
// one outstanding at a time. Sub-word stores are read-modify-write.
// Ports:
//   clock, reset_n                     clock and synchronous active-low reset
//   req_valid/req_ready                request handshake
//   req_we, req_size, req_signed       request kind
//   req_addr, req_wdata                byte address, right-aligned store data
//   rsp_valid/rsp_ready                response handshake
//   rsp_rdata, rsp_err                 load result / error flag
//   mwr, moe, ma, mwd                  memory write, read marker, word index, write data
//   mrd                                memory read data (combinational from ma)
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int ADDR_W      = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mwr,
  output logic              moe,
  output logic [ADDR_W-1:0] ma,
  output logic [31:0]       mwd,
  input  logic [31:0]       mrd
);

  lsu_state_e        state_r, state_nxt_s;
  logic              we_r;
  logic [1:0]        size_r;
  logic              sign_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [31:0]       wword_r;
  logic [31:0]       rdata_r;
  logic              err_r;

  logic              accept_s;
  logic [ADDR_W-1:0] req_idx_s;
  logic              req_err_s;
  logic [31:0]       load_val_s;
  logic [31:0]       merged_s;

  assign accept_s  = req_valid & req_ready;
  assign req_idx_s = {2'b00, req_addr[ADDR_W-1:2]};
  assign req_err_s = align_err(req_size, req_addr[1:0]) |
                     (req_idx_s >= ADDR_W'(DEPTH_WORDS));

  mem_lane_align u_align (
    .word      (mrd),
    .addr_lo   (addr_r[1:0]),
    .size      (size_r),
    .is_signed (sign_r),
    .wdata     (wdata_r),
    .load_val  (load_val_s),
    .merged    (merged_s)
  );

  // Next-state selection; errors skip memory, sub-word stores read first.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (req_err_s) begin
            state_nxt_s = RESP;
          end else if (!req_we || (req_size != SZ_WORD)) begin
            state_nxt_s = READ;
          end else begin
            state_nxt_s = WRITE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ:    state_nxt_s = we_r ? WRITE : RESP;
      WRITE:   state_nxt_s = RESP;
      RESP:    state_nxt_s = rsp_ready ? IDLE : RESP;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register plus request capture, load result and RMW merge word.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= IDLE;
      we_r    <= 1'b0;
      size_r  <= 2'b00;
      sign_r  <= 1'b0;
      addr_r  <= '0;
      wdata_r <= 32'h0000_0000;
      wword_r <= 32'h0000_0000;
      rdata_r <= 32'h0000_0000;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            we_r    <= req_we;
            size_r  <= req_size;
            sign_r  <= req_signed;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            wword_r <= req_wdata;
            rdata_r <= 32'h0000_0000;
            err_r   <= req_err_s;
          end
        end
        READ: begin
          if (we_r) begin
            wword_r <= merged_s;
          end else begin
            rdata_r <= load_val_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake and memory port decode; reset_n gates anything that must be quiet in reset.
  always_comb begin
    req_ready = reset_n & (state_r == IDLE);
    rsp_valid = reset_n & (state_r == RESP);
    rsp_err   = rsp_valid & err_r;
    rsp_rdata = rsp_valid ? rdata_r : 32'h0000_0000;
    moe       = (state_r == READ);
    mwr       = reset_n & (state_r == WRITE);
    ma        = ((state_r == READ) || (state_r == WRITE)) ? {2'b00, addr_r[ADDR_W-1:2]} : '0;
    mwd       = (state_r == WRITE) ? wword_r : 32'h0000_0000;
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for mem_lsu with a 128-word
// behavioural memory attached to the memory port.
module tb_mem_lsu;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mwr, moe;
  logic [31:0] ma, mwd, mrd;

  logic [31:0] mem [0:127];

  int vectors = 0;
  int miscompares = 0;

  int          lat, moe_cnt, moe_at, mwr_cnt, mwr_at;
  logic [31:0] wr_ma, wr_mwd, ob_rdata;
  logic        ob_err;

  mem_lsu dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mwr(mwr), .moe(moe),
    .ma(ma), .mwd(mwd), .mrd(mrd)
  );

  always #5 clock = ~clock;

  assign mrd = (ma < 32'd128) ? mem[ma[6:0]] : 32'h0000_0000;

  always @(posedge clock) begin
    if (mwr) mem[ma[6:0]] <= mwd;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one request with rsp_ready high and record what the memory port and response do.
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd);
    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = ad; req_wdata = wd; rsp_ready = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = -1; moe_cnt = 0; moe_at = 0; mwr_cnt = 0; mwr_at = 0;
    wr_ma = 32'hX; wr_mwd = 32'hX; ob_rdata = 32'hX; ob_err = 1'bX;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (moe) begin moe_cnt++; moe_at = k; end
      if (mwr) begin mwr_cnt++; mwr_at = k; wr_ma = ma; wr_mwd = mwd; end
      if (rsp_valid) begin lat = k; ob_rdata = rsp_rdata; ob_err = rsp_err; break; end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
    req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h1234_5678; rsp_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_req_ready got %b exp 0", req_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_err got %b exp 0", rsp_err); end
    vectors++; if (rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rsp_rdata got %h exp 0", rsp_rdata); end
    vectors++; if ({mwr, moe} !== 2'b00) begin miscompares++; $display("FAIL rst_mwr_moe got %b exp 00", {mwr, moe}); end
    vectors++; if ({ma, mwd} !== 64'h0) begin miscompares++; $display("FAIL rst_ma_mwd got %h exp 0", {ma, mwd}); end
    req_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_word_store();
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL ws_latency got %0d exp 2", lat); end
    vectors++; if (mwr_cnt !== 1 || mwr_at !== 1) begin miscompares++; $display("FAIL ws_mwr got cnt %0d at %0d exp cnt 1 at 1", mwr_cnt, mwr_at); end
    vectors++; if (wr_ma !== 32'd4) begin miscompares++; $display("FAIL ws_ma got %h exp 4", wr_ma); end
    vectors++; if (wr_mwd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL ws_mwd got %h exp deadbeef", wr_mwd); end
    vectors++; if (moe_cnt !== 0) begin miscompares++; $display("FAIL ws_moe got %0d exp 0", moe_cnt); end
    vectors++; if ({ob_err, ob_rdata} !== 33'h0) begin miscompares++; $display("FAIL ws_rsp got err %b rdata %h exp 0 0", ob_err, ob_rdata); end
  endtask

  task automatic test_loads();
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    vectors++; if (ob_rdata !== 32'hFFFF_FFDE) begin miscompares++; $display("FAIL ld_sbyte got %h exp ffffffde", ob_rdata); end
    vectors++; if (lat !== 2 || moe_cnt !== 1 || mwr_cnt !== 0) begin miscompares++; $display("FAIL ld_timing got lat %0d moe %0d mwr %0d exp 2 1 0", lat, moe_cnt, mwr_cnt); end
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    vectors++; if (ob_rdata !== 32'h0000_DEAD) begin miscompares++; $display("FAIL ld_uhalf got %h exp 0000dead", ob_rdata); end
    issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    vectors++; if (ob_rdata !== 32'hFFFF_DEAD) begin miscompares++; $display("FAIL ld_shalf got %h exp ffffdead", ob_rdata); end
    issue(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    vectors++; if (ob_rdata !== 32'h0000_00EF) begin miscompares++; $display("FAIL ld_ubyte got %h exp 000000ef", ob_rdata); end
    vectors++; if (ob_err !== 1'b0) begin miscompares++; $display("FAIL ld_err got %b exp 0", ob_err); end
  endtask

  task automatic test_subword_store();
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AA);
    vectors++; if (moe_at !== 1 || moe_cnt !== 1) begin miscompares++; $display("FAIL bs_moe got at %0d cnt %0d exp 1 1", moe_at, moe_cnt); end
    vectors++; if (mwr_at !== 2 || mwr_cnt !== 1) begin miscompares++; $display("FAIL bs_mwr got at %0d cnt %0d exp 2 1", mwr_at, mwr_cnt); end
    vectors++; if (wr_mwd !== 32'hDEAD_AAEF) begin miscompares++; $display("FAIL bs_mwd got %h exp deadaaef", wr_mwd); end
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL bs_latency got %0d exp 3", lat); end
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    vectors++; if (ob_rdata !== 32'hDEAD_AAEF) begin miscompares++; $display("FAIL bs_readback got %h exp deadaaef", ob_rdata); end
    issue(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_1234);
    vectors++; if (wr_mwd !== 32'h1234_AAEF || wr_ma !== 32'd4) begin miscompares++; $display("FAIL hs_mwd got %h ma %h exp 1234aaef 4", wr_mwd, wr_ma); end
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    vectors++; if (ob_rdata !== 32'hFFFF_AAEF) begin miscompares++; $display("FAIL hs_readback got %h exp ffffaaef", ob_rdata); end
  endtask

  task automatic test_errors();
    issue(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
    vectors++; if (ob_err !== 1'b1 || lat !== 1) begin miscompares++; $display("FAIL err_misal_half got err %b lat %0d exp 1 1", ob_err, lat); end
    vectors++; if (moe_cnt !== 0 || mwr_cnt !== 0 || ob_rdata !== 32'h0) begin miscompares++; $display("FAIL err_misal_quiet got moe %0d mwr %0d rdata %h exp 0 0 0", moe_cnt, mwr_cnt, ob_rdata); end
    issue(1'b1, 2'b10, 1'b0, 32'h200, 32'h5555_5555);
    vectors++; if (ob_err !== 1'b1 || mwr_cnt !== 0 || lat !== 1) begin miscompares++; $display("FAIL err_range got err %b mwr %0d lat %0d exp 1 0 1", ob_err, mwr_cnt, lat); end
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    vectors++; if (ob_err !== 1'b1 || moe_cnt !== 0) begin miscompares++; $display("FAIL err_size got err %b moe %0d exp 1 0", ob_err, moe_cnt); end
    issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    vectors++; if (ob_err !== 1'b1) begin miscompares++; $display("FAIL err_misal_word got %b exp 1", ob_err); end
    issue(1'b0, 2'b10, 1'b0, 32'h1FC, 32'h0);
    vectors++; if (ob_err !== 1'b0 || lat !== 2 || ob_rdata !== 32'h0) begin miscompares++; $display("FAIL last_index got err %b lat %0d rdata %h exp 0 2 0", ob_err, lat, ob_rdata); end
  endtask

  task automatic test_backpressure();
    int seen;
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0; rsp_ready = 1'b0;
    @(posedge clock); #1;
    // second request presented while the load is outstanding
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D;
    seen = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      @(negedge clock);
      if (rsp_valid) seen = 1;
    end
    vectors++; if (seen !== 1) begin miscompares++; $display("FAIL bp_rsp_arrive got %0d exp 1", seen); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clock);
      vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_AAEF) begin miscompares++; $display("FAIL bp_hold got valid %b rdata %h exp 1 1234aaef", rsp_valid, rsp_rdata); end
      vectors++; if (req_ready !== 1'b0 || mwr !== 1'b0) begin miscompares++; $display("FAIL bp_block got ready %b mwr %b exp 0 0", req_ready, mwr); end
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    vectors++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release got ready %b valid %b exp 1 0", req_ready, rsp_valid); end
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    vectors++; if (mwr !== 1'b1 || ma !== 32'd8 || mwd !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL bp_second got mwr %b ma %h mwd %h exp 1 8 cafef00d", mwr, ma, mwd); end
    @(posedge clock);
    @(negedge clock);
    vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL bp_second_rsp got valid %b err %b exp 1 0", rsp_valid, rsp_err); end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid();
    int wr_seen;
    wr_seen = 0;
    // reset during the READ cycle of a byte store
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0000_0055; rsp_ready = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (mwr) wr_seen++;
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    if (mwr) wr_seen++;
    vectors++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rm_read_after got ready %b valid %b exp 1 0", req_ready, rsp_valid); end
    vectors++; if (wr_seen !== 0 || mem[4] !== 32'h1234_AAEF) begin miscompares++; $display("FAIL rm_read_mem got writes %0d mem %h exp 0 1234aaef", wr_seen, mem[4]); end
    // reset during the WRITE cycle of a word store
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h10; req_wdata = 32'h1111_1111;
    @(posedge clock); #1;
    req_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    vectors++; if (mwr !== 1'b0) begin miscompares++; $display("FAIL rm_write_mwr got %b exp 0", mwr); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    vectors++; if (mem[4] !== 32'h1234_AAEF || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rm_write_mem got mem %h valid %b exp 1234aaef 0", mem[4], rsp_valid); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    test_reset();
    test_word_store();
    test_loads();
    test_subword_store();
    test_errors();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Load/store unit that initiates all accesses to the word-addressed data memory on behalf of the processor datapath. It accepts byte-addressed load/store requests with byte, halfword and word sizes over a valid/ready handshake. It drives the memory port signals mwr, moe, ma and mwd, and samples mrd. Sub-word stores are performed as read-modify-write, because the memory only writes whole words.

Parameters:
DEPTH_WORDS, 128, number of 32-bit words in the data memory; word index >= DEPTH_WORDS is out of range.
ADDR_W, 32, width of request byte address and of ma.

Ports:
clock  input  1  system clock, all state on posedge.
reset_n  input  1  one clock; reset is synchronous and active-low.
req_valid  input  1  request present.
req_ready  output  1  unit can accept a request.
req_we  input  1  1 = store, 0 = load.
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
req_signed  input  1  sign-extend loaded byte/half.
req_addr  input  ADDR_W  byte address.
req_wdata  input  32  store data, right-aligned (lane 0).
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer takes response.
rsp_rdata  output  32  load result, extended; 0 for stores and errors.
rsp_err  output  1  misaligned, illegal size or out-of-range.
mwr  output  1  memory write enable.
moe  output  1  memory output enable (read cycle marker).
ma  output  ADDR_W  memory word index (req_addr >> 2).
mwd  output  32  memory write data.
mrd  input  32  memory read data, combinational from ma.

Behaviour:
- Reset (reset_n low at posedge): state goes to IDLE; all captured registers are cleared to 0.
  - While reset_n is low: req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - mwr is gated by reset_n, so no write commits in a reset cycle.
  - moe=0, ma=0, mwd=0 outside READ/WRITE.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - Accept when req_valid && req_ready at edge T. Capture we, size, signed, addr, wdata.
  - Error checks: size 11; half with addr[0]!=0; word with addr[1:0]!=0; (addr>>2) >= DEPTH_WORDS.
  - Error -> RESP with err=1, no memory cycle.
  - Load -> READ. Word store -> WRITE. Byte/half store -> READ.
- READ (exactly 1 cycle):
  - moe=1, ma=captured word index.
  - mrd is sampled at the end of the cycle.
  - Load: extract lane (byte lane=addr[1:0], half lane=addr[1]; little-endian), zero/sign-extend into rsp_rdata reg -> RESP.
  - Store: merge wdata lane into sampled word -> WRITE.
- WRITE (exactly 1 cycle):
  - mwr=1, ma=index, mwd=merged or full word.
  - Memory commits at the end-of-cycle edge -> RESP.
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_err held stable until rsp_ready.
  - On rsp_valid && rsp_ready -> IDLE.
  - req_ready=0 in all non-IDLE states (no pipelining; one outstanding request).
- Latency (accept edge T, response visible in the cycle after the given edge):
  - Load: RESP after edge T+2.
  - Word store: RESP after edge T+2.
  - Sub-word store: RESP after edge T+3.
  - Error: RESP after edge T+1.
- mwr is high for exactly one cycle per store and never for loads or errors. moe is high for one cycle per load or sub-word store.
- Reset mid-operation: transaction abandoned, no response.
  - Reset in the READ cycle of an RMW: no write occurs.
  - Reset in the WRITE cycle: the write is suppressed.
- rsp_rdata upper bits: byte unsigned zero-extends bits 31:8; byte signed replicates bit 7. Half behaves analogously with bit 15.

Decomposition:
- Package mem_lsu_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state enum {IDLE, READ, WRITE, RESP};
  - default DEPTH_WORDS.
- One combinational sub-module, mem_lane_align, implements lane extract+extend for loads and lane merge for stores. Inputs: word, addr[1:0], size, signed, wdata. Outputs: load value, merged word.

Test Plan:
- Word store addr 0x10, data 0xDEADBEEF -> one mwr cycle with ma=4, mwd=0xDEADBEEF; rsp_valid after T+2, err=0, rdata=0.
- After prior store: signed byte load 0x13 -> rsp_rdata=0xFFFFFFDE; unsigned half load 0x12 -> 0x0000DEAD; unsigned byte load 0x10 -> 0x000000EF.
- Byte store 0x11, wdata 0x000000AA -> moe cycle T+1, mwr cycle T+2, mwd=0xDEADAAEF; word load 0x10 then returns 0xDEADAAEF.
- Half load 0x11 -> err=1 at T+1, moe/mwr never asserted; word store 0x200 (index 128) -> err=1, no mwr; size 11 -> err=1.
- Response backpressure: rsp_ready low 3 cycles on load -> rsp_valid/rdata stable, req_ready=0, second request not accepted until the handshake completes.
- reset_n low in the READ cycle of a byte store to 0x10 -> no mwr, memory unchanged, req_ready=1 the cycle after reset_n returns high.
